// File: rtl/ascon_host.sv
// ascon_host: host-side initiator for the ascon AEAD core.
// Takes one job (key, nonce, lengths, mode) plus a source word stream, feeds the
// core's key/nonce/assoc/data channels in order, forwards the core's output words,
// and captures and checks the tag, with a timeout on the tag wait.
module ascon_host #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int LEN_W          = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [127:0]      key,
    input  logic [127:0]      nonce,
    input  logic [127:0]      exp_tag,
    input  logic [LEN_W-1:0]  assoc_len,
    input  logic [LEN_W-1:0]  data_len,
    input  logic [31:0]       src_data,
    input  logic              src_valid,
    output logic              src_ready,
    output logic              core_rst,
    output logic              core_mode,
    output logic [31:0]       key_out,
    output logic [31:0]       nonce_out,
    output logic [31:0]       assoc_out,
    output logic [31:0]       data_out,
    output logic              key_valid,
    output logic              nonce_valid,
    output logic              assoc_valid,
    output logic              data_valid,
    input  logic              key_ready,
    input  logic              nonce_ready,
    input  logic              assoc_ready,
    input  logic              data_ready,
    output logic [1:0]        data_type,
    output logic              data_last,
    input  logic [31:0]       core_dout,
    input  logic              core_dout_valid,
    input  logic              core_dout_last,
    input  logic [127:0]      core_tag,
    input  logic              core_tag_valid,
    output logic [31:0]       res_data,
    output logic              res_valid,
    output logic              res_last,
    output logic [127:0]      tag_out,
    output logic              tag_ok,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_NONCE,
        S_ASSOC,
        S_DATA,
        S_WAIT_TAG
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;

    logic               r_mode;
    logic [127:0]       r_key;
    logic [127:0]       r_nonce;
    logic [127:0]       r_exp_tag;
    logic [LEN_W-1:0]   r_alen;
    logic [LEN_W-1:0]   r_dlen;
    logic [LEN_W-1:0]   r_cnt;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_core_rst;
    logic               r_done;
    logic               r_err;
    logic               r_tag_ok;
    logic [127:0]       r_tag;
    logic [31:0]        r_res_data;
    logic               r_res_valid;
    logic               r_res_last;

    logic               w_start_ok;
    logic               w_start_bad;
    logic               w_tag_hit;
    logic               w_tmo_exp;
    logic               w_cnt_inc;
    logic               w_cnt_clr;
    logic               w_tmo_load;
    logic               w_busy;
    logic [6:0]         w_widx;

    // Bit offset of the current 32-bit key/nonce word (word 0 is bits 31:0).
    assign w_widx = {r_cnt[1:0], 5'd0};
    assign w_busy = (r_state != S_IDLE);

    // State register; reset aborts any job straight back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic, word-counter control and core channel drive.
    always_comb begin
        w_state_nx  = r_state;
        w_start_ok  = 1'b0;
        w_start_bad = 1'b0;
        w_tag_hit   = 1'b0;
        w_tmo_exp   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_tmo_load  = 1'b0;
        key_valid   = 1'b0;
        key_out     = '0;
        nonce_valid = 1'b0;
        nonce_out   = '0;
        assoc_valid = 1'b0;
        assoc_out   = '0;
        data_valid  = 1'b0;
        data_out    = '0;
        data_type   = 2'd0;
        data_last   = 1'b0;
        src_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (data_len == '0) begin
                        w_start_bad = 1'b1;
                    end else begin
                        w_start_ok = 1'b1;
                        w_state_nx = S_KEY;
                    end
                end
            end
            S_KEY: begin
                key_valid = 1'b1;
                key_out   = r_key[w_widx +: 32];
                if (key_ready) begin
                    if (r_cnt[1:0] == 2'd3) begin
                        w_cnt_clr  = 1'b1;
                        w_state_nx = S_NONCE;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            S_NONCE: begin
                nonce_valid = 1'b1;
                nonce_out   = r_nonce[w_widx +: 32];
                if (nonce_ready) begin
                    if (r_cnt[1:0] == 2'd3) begin
                        w_cnt_clr  = 1'b1;
                        w_state_nx = (r_alen == '0) ? S_DATA : S_ASSOC;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            S_ASSOC: begin
                assoc_valid = src_valid;
                assoc_out   = src_data;
                src_ready   = assoc_ready;
                if (src_valid && assoc_ready) begin
                    if (r_cnt == r_alen - LEN_W'(1)) begin
                        w_cnt_clr  = 1'b1;
                        w_state_nx = S_DATA;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            S_DATA: begin
                data_valid = src_valid;
                data_out   = src_data;
                data_type  = r_mode ? 2'd1 : 2'd2;
                data_last  = (r_cnt == r_dlen - LEN_W'(1));
                src_ready  = data_ready;
                if (src_valid && data_ready) begin
                    if (data_last) begin
                        w_cnt_clr  = 1'b1;
                        w_tmo_load = 1'b1;
                        w_state_nx = S_WAIT_TAG;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            S_WAIT_TAG: begin
                // A tag arriving on the expiry cycle still counts as success.
                if (core_tag_valid) begin
                    w_tag_hit  = 1'b1;
                    w_state_nx = S_IDLE;
                end else if (r_tmo <= TMO_W'(1)) begin
                    w_tmo_exp  = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Job latches, counters, result capture and registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode      <= 1'b0;
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_core_rst  <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_tag_ok    <= 1'b0;
            r_tag       <= '0;
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
            r_res_last  <= 1'b0;
        end else begin
            r_core_rst  <= (w_state_nx == S_IDLE);
            r_done      <= w_tag_hit;
            r_err       <= w_start_bad | w_tmo_exp;
            r_res_data  <= w_busy ? core_dout : '0;
            r_res_valid <= w_busy & core_dout_valid;
            r_res_last  <= w_busy & core_dout_valid & core_dout_last;

            if (w_start_ok) begin
                r_mode    <= mode;
                r_key     <= key;
                r_nonce   <= nonce;
                r_exp_tag <= exp_tag;
                r_alen    <= assoc_len;
                r_dlen    <= data_len;
                r_cnt     <= '0;
                r_tag     <= '0;
                r_tag_ok  <= 1'b0;
            end else if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + LEN_W'(1);
            end

            if (w_tmo_load) begin
                r_tmo <= TMO_W'(TIMEOUT_CYCLES);
            end else if (r_state == S_WAIT_TAG && r_tmo != '0) begin
                r_tmo <= r_tmo - TMO_W'(1);
            end

            if (w_tag_hit) begin
                r_tag    <= core_tag;
                r_tag_ok <= r_mode ? 1'b1 : (core_tag == r_exp_tag);
            end else if (w_tmo_exp) begin
                r_tag_ok <= 1'b0;
            end
        end
    end

    assign core_rst  = r_core_rst;
    assign core_mode = r_mode;
    assign res_data  = r_res_data;
    assign res_valid = r_res_valid;
    assign res_last  = r_res_last;
    assign tag_out   = r_tag;
    assign tag_ok    = r_tag_ok;
    assign busy      = w_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_ascon_host.sv
// tb_ascon_host: directed bench for ascon_host with a small behavioural core model.
module tb_ascon_host;

    localparam int TMO   = 64;
    localparam int LEN_W = 4;
    localparam logic [31:0] DMASK = 32'hFFFF0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              mode;
    logic [127:0]      key;
    logic [127:0]      nonce;
    logic [127:0]      exp_tag;
    logic [LEN_W-1:0]  assoc_len;
    logic [LEN_W-1:0]  data_len;
    logic [31:0]       src_data;
    logic              src_valid;
    logic              src_ready;
    logic              core_rst;
    logic              core_mode;
    logic [31:0]       key_out, nonce_out, assoc_out, data_out;
    logic              key_valid, nonce_valid, assoc_valid, data_valid;
    logic              key_ready, nonce_ready, assoc_ready, data_ready;
    logic [1:0]        data_type;
    logic              data_last;
    logic [31:0]       core_dout;
    logic              core_dout_valid;
    logic              core_dout_last;
    logic [127:0]      core_tag;
    logic              core_tag_valid;
    logic [31:0]       res_data;
    logic              res_valid;
    logic              res_last;
    logic [127:0]      tag_out;
    logic              tag_ok;
    logic              busy;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    ascon_host #(.TIMEOUT_CYCLES(TMO), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .key(key), .nonce(nonce),
        .exp_tag(exp_tag), .assoc_len(assoc_len), .data_len(data_len),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .core_rst(core_rst), .core_mode(core_mode),
        .key_out(key_out), .nonce_out(nonce_out), .assoc_out(assoc_out), .data_out(data_out),
        .key_valid(key_valid), .nonce_valid(nonce_valid), .assoc_valid(assoc_valid),
        .data_valid(data_valid), .key_ready(key_ready), .nonce_ready(nonce_ready),
        .assoc_ready(assoc_ready), .data_ready(data_ready), .data_type(data_type),
        .data_last(data_last), .core_dout(core_dout), .core_dout_valid(core_dout_valid),
        .core_dout_last(core_dout_last), .core_tag(core_tag), .core_tag_valid(core_tag_valid),
        .res_data(res_data), .res_valid(res_valid), .res_last(res_last),
        .tag_out(tag_out), .tag_ok(tag_ok), .busy(busy), .done(done), .err(err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Core model tag: an order-sensitive fold of every word it received.
    function automatic logic [31:0] acc_step(input logic [31:0] a, input logic [31:0] w);
        return {a[30:0], a[31]} ^ w;
    endfunction

    function automatic logic [127:0] mk_tag(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A5A5A, a + 32'd1};
    endfunction

    // Stimulus and bench control
    logic [31:0] src_mem [16];
    int          src_n   = 0;
    logic        clr     = 1'b0;
    logic        rdy_rand  = 1'b0;
    logic        data_hold = 1'b0;
    logic        tag_en    = 1'b1;

    // Model / monitor state
    int          cyc = 0;
    logic [31:0] key_log [16];
    logic [31:0] nonce_log [16];
    logic [31:0] assoc_log [16];
    logic [31:0] data_log [16];
    logic [31:0] res_log [16];
    logic [15:0] last_bits;
    int          key_n, nonce_n, assoc_n, data_n, res_n, res_last_n;
    int          done_n, err_n, err_cyc, xfer_cyc, src_idx, tag_cnt;
    logic [1:0]  dtype_seen;
    logic        assoc_seen;
    logic [31:0] acc;

    always @(posedge clk) cyc <= cyc + 1;

    // Channel monitor plus behavioural core responses.
    always @(posedge clk) begin
        if (clr) begin
            key_n <= 0; nonce_n <= 0; assoc_n <= 0; data_n <= 0; res_n <= 0; res_last_n <= 0;
            done_n <= 0; err_n <= 0; err_cyc <= 0; xfer_cyc <= 0; src_idx <= 0; tag_cnt <= 0;
            last_bits <= '0; dtype_seen <= 2'd0; assoc_seen <= 1'b0; acc <= '0;
            core_dout_valid <= 1'b0; core_dout_last <= 1'b0; core_dout <= '0;
            core_tag_valid <= 1'b0; core_tag <= '0;
        end else begin
            core_dout_valid <= 1'b0;
            core_dout_last  <= 1'b0;
            core_tag_valid  <= 1'b0;
            if (key_valid && key_ready) begin
                key_log[key_n] <= key_out; key_n <= key_n + 1; acc <= acc_step(acc, key_out);
            end
            if (nonce_valid && nonce_ready) begin
                nonce_log[nonce_n] <= nonce_out; nonce_n <= nonce_n + 1; acc <= acc_step(acc, nonce_out);
            end
            if (assoc_valid && assoc_ready) begin
                assoc_log[assoc_n] <= assoc_out; assoc_n <= assoc_n + 1; acc <= acc_step(acc, assoc_out);
            end
            if (data_valid && data_ready) begin
                data_log[data_n] <= data_out; last_bits[data_n] <= data_last; data_n <= data_n + 1;
                acc <= acc_step(acc, data_out); dtype_seen <= data_type;
                core_dout_valid <= 1'b1; core_dout <= data_out ^ DMASK; core_dout_last <= data_last;
                if (data_last) begin
                    tag_cnt <= 5; xfer_cyc <= cyc;
                end
            end
            if (src_valid && src_ready) src_idx <= src_idx + 1;
            if (tag_cnt != 0) begin
                tag_cnt <= tag_cnt - 1;
                if (tag_cnt == 1 && tag_en) begin
                    core_tag_valid <= 1'b1; core_tag <= mk_tag(acc);
                end
            end
            if (assoc_valid) assoc_seen <= 1'b1;
            if (res_valid) begin
                res_log[res_n] <= res_data; res_n <= res_n + 1;
                if (res_last) res_last_n <= res_last_n + 1;
            end
            if (done) done_n <= done_n + 1;
            if (err) begin
                err_n <= err_n + 1; err_cyc <= cyc;
            end
        end
    end

    // Readies and source stream, changed only on the falling edge.
    always @(negedge clk) begin
        key_ready   = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        nonce_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        assoc_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        data_ready  = data_hold ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        src_valid   = (src_idx < src_n) && (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        src_data    = (src_idx < 16) ? src_mem[src_idx] : 32'h0;
    end

    task automatic load_src(input int alen, input int dlen);
        for (int i = 0; i < alen; i++) src_mem[i] = 32'hA0000000 + i;
        for (int i = 0; i < dlen; i++) src_mem[alen + i] = 32'hD0000000 + i;
        src_mem[alen + dlen] = 32'hDEADBEEF;
        src_n = alen + dlen + 1;
    endtask

    function automatic logic [31:0] exp_acc(input int nw);
        logic [31:0] a = '0;
        for (int i = 0; i < 4; i++) a = acc_step(a, key[32*i +: 32]);
        for (int i = 0; i < 4; i++) a = acc_step(a, nonce[32*i +: 32]);
        for (int i = 0; i < nw; i++) a = acc_step(a, src_mem[i]);
        return a;
    endfunction

    task automatic begin_job(input logic m, input int alen, input int dlen, input logic [127:0] et);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        mode = m; assoc_len = LEN_W'(alen); data_len = LEN_W'(dlen); exp_tag = et; start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("key_valid_after_start", key_valid, 1'b1);
    endtask

    task automatic run_job(input logic m, input int alen, input int dlen, input logic [127:0] et,
                           input int bound);
        begin_job(m, alen, dlen, et);
        for (int c = 0; c < bound && (done_n + err_n) == 0; c++) @(negedge clk);
        check("job_ended_in_bound", 32'((done_n + err_n) != 0), 32'd1);
    endtask

    task automatic check_stream(input int alen, input int dlen);
        check("nonce_count", nonce_n, 4);
        check("assoc_count", assoc_n, alen);
        check("data_count", data_n, dlen);
        for (int i = 0; i < alen; i++) check($sformatf("assoc_word%0d", i), assoc_log[i], src_mem[i]);
        for (int i = 0; i < dlen; i++) check($sformatf("data_word%0d", i), data_log[i], src_mem[alen + i]);
        check("res_count", res_n, dlen);
        for (int i = 0; i < dlen; i++)
            check($sformatf("res_word%0d", i), res_log[i], src_mem[alen + i] ^ DMASK);
        check("src_extra_not_consumed", src_idx, alen + dlen);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; exp_tag = '0; assoc_len = '0; data_len = '0;
        key   = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        nonce = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        clr = 1'b1;
        repeat (3) @(negedge clk);
        // reset state
        check("rst_core_rst", core_rst, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_valids", {key_valid, nonce_valid, assoc_valid, data_valid}, 4'b0);
        check("rst_src_ready", src_ready, 1'b0);
        check("rst_status", {done, err, tag_ok, res_valid, res_last, core_mode}, 6'b0);
        check("rst_tag_out", tag_out, 128'h0);
        check("rst_outs", {key_out, nonce_out, assoc_out, data_out, res_data}, 160'h0);
        rst = 1'b0; clr = 1'b0;
        @(negedge clk);

        // encrypt, assoc_len=1, data_len=2
        load_src(1, 2);
        run_job(1'b1, 1, 2, '0, 200);
        check("enc_key_count", key_n, 4);
        check("enc_key0", key_log[0], 32'h03020100);
        check("enc_key1", key_log[1], 32'h07060504);
        check("enc_key2", key_log[2], 32'h0B0A0908);
        check("enc_key3", key_log[3], 32'h0F0E0D0C);
        check("enc_nonce0", nonce_log[0], 32'h03020100);
        check("enc_nonce3", nonce_log[3], 32'h0F0E0D0C);
        check_stream(1, 2);
        check("enc_data_last_bits", last_bits[1:0], 2'b10);
        check("enc_res_last", res_last_n, 1);
        check("enc_dtype", dtype_seen, 2'd1);
        check("enc_done", done_n, 1);
        check("enc_err", err_n, 0);
        check("enc_tag_ok", tag_ok, 1'b1);
        check("enc_tag_out", tag_out, mk_tag(exp_acc(3)));
        check("enc_core_mode", core_mode, 1'b1);
        check("enc_idle", busy, 1'b0);

        // decrypt with the model's tag, then with bit 0 flipped
        load_src(2, 3);
        run_job(1'b0, 2, 3, mk_tag(exp_acc(5)), 200);
        check_stream(2, 3);
        check("dec_dtype", dtype_seen, 2'd2);
        check("dec_done", done_n, 1);
        check("dec_tag_ok", tag_ok, 1'b1);
        load_src(2, 3);
        run_job(1'b0, 2, 3, mk_tag(exp_acc(5)) ^ 128'h1, 200);
        check("decbad_done", done_n, 1);
        check("decbad_tag_ok", tag_ok, 1'b0);

        // no associated data
        load_src(0, 3);
        run_job(1'b1, 0, 3, '0, 200);
        check_stream(0, 3);
        check("noassoc_valid_seen", assoc_seen, 1'b0);
        check("noassoc_done", done_n, 1);

        // random stalls on every channel
        rdy_rand = 1'b1;
        load_src(3, 5);
        run_job(1'b1, 3, 5, '0, 1000);
        check("stall_key_count", key_n, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("stall_key%0d", i), key_log[i], 32'h03020100 + 32'h04040404 * i);
        check_stream(3, 5);
        check("stall_last_bits", last_bits[4:0], 5'b10000);
        check("stall_done", done_n, 1);
        rdy_rand = 1'b0;

        // no tag from the core: timeout
        tag_en = 1'b0;
        load_src(1, 2);
        run_job(1'b1, 1, 2, '0, 300);
        check("tmo_err", err_n, 1);
        check("tmo_done", done_n, 0);
        // err rose on the edge before the one that first saw it
        check("tmo_distance", err_cyc - 1 - xfer_cyc, TMO);
        check("tmo_tag_ok", tag_ok, 1'b0);
        check("tmo_idle", busy, 1'b0);
        tag_en = 1'b1;

        // start with data_len = 0
        @(negedge clk);
        assoc_len = '0; data_len = '0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("badjob_err", err, 1'b1);
        check("badjob_busy", busy, 1'b0);
        @(negedge clk);
        check("badjob_err_pulse", err, 1'b0);
        check("badjob_busy_after", busy, 1'b0);

        // reset in the middle of DATA
        data_hold = 1'b1;
        load_src(1, 3);
        begin_job(1'b1, 1, 3, '0);
        for (int c = 0; c < 100 && !data_valid; c++) @(negedge clk);
        check("midrst_reached_data", data_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_valids", {key_valid, nonce_valid, assoc_valid, data_valid}, 4'b0);
        check("midrst_src_ready", src_ready, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_core_rst", core_rst, 1'b1);
        data_hold = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_no_done", done_n, 0);
        check("midrst_no_err", err_n, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
